// File: rtl/decode_queue_if.sv
// Decoded-instruction types and the fetch/issue bus of the decode queue.
// The package comes first because the interface and the queue both use its types.
package decode_queue_pkg;

  // Execute-class operation. Immediate forms reuse the ALU op of their
  // register form and are told apart by ctl.alusrcb.
  typedef enum logic [4:0] {
    OP_ADDU, OP_SUBU, OP_SLT, OP_SLTU, OP_AND, OP_NOR, OP_OR, OP_XOR,
    OP_SLL, OP_SRA, OP_SRL, OP_JR, OP_LUI, OP_BEQ, OP_BNE, OP_J,
    OP_JAL, OP_LW, OP_SW, OP_RESERVED
  } op_t;

  typedef enum logic {
    ALUSRC_REG,
    ALUSRC_IMM
  } alusrc_t;

  typedef struct packed {
    logic    regwrite;
    alusrc_t alusrcb;
    logic    zeroext;
    logic    is_link;
    logic    memread;
    logic    memwrite;
    logic    branch;
    logic    jump;
    logic    jump_reg;
  } ctl_t;

  typedef struct packed {
    op_t         op;
    ctl_t        ctl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [4:0]  writereg;
    logic [31:0] extended_imm;
  } decoded_instr_t;

endpackage

// Fetch-side push port plus issue-side decoded window.
interface decode_queue_if #(
  parameter int DEPTH       = 4,
  parameter int ISSUE_WIDTH = 2
);
  import decode_queue_pkg::*;

  localparam int CNT_W = $clog2(ISSUE_WIDTH + 1);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic                                in_valid;
  logic                                in_ready;
  logic [31:0]                         in_instr;
  logic [31:0]                         in_pc;
  logic                                flush;
  logic [ISSUE_WIDTH-1:0]              out_valid;
  decoded_instr_t [ISSUE_WIDTH-1:0]    out_decoded;
  logic [ISSUE_WIDTH-1:0][31:0]        out_pc;
  logic [ISSUE_WIDTH-1:0]              out_reserved;
  logic [CNT_W-1:0]                    out_accept;
  logic [OCC_W-1:0]                    count;

  // Queue side.
  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_accept,
    output in_ready, out_valid, out_decoded, out_pc, out_reserved, count
  );

  // Fetch/issue side.
  modport master (
    output in_valid, in_instr, in_pc, flush, out_accept,
    input  in_ready, out_valid, out_decoded, out_pc, out_reserved, count
  );

endinterface

// File: rtl/decode_queue.sv
// Decode queue: circular FIFO of fetched {instr, pc} with the oldest
// ISSUE_WIDTH entries presented already decoded. In-order partial dequeue,
// flush on redirect, reserved-opcode flagging per slot.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int ISSUE_WIDTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  decode_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(ISSUE_WIDTH + 1);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int SUM_W = (OCC_W > CNT_W) ? OCC_W : CNT_W;

  logic [31:0]      r_instr_mem [DEPTH];
  logic [31:0]      r_pc_mem    [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [OCC_W-1:0] r_count;

  logic             w_in_ready;
  logic             w_enq;
  logic [SUM_W-1:0] w_accept_ext;
  logic [SUM_W-1:0] w_count_ext;
  logic [OCC_W-1:0] w_k;
  logic [OCC_W-1:0] w_count_next;

  // Decode one raw word into the core's control bundle.
  function automatic decoded_instr_t decode_instr(input logic [31:0] instr);
    decoded_instr_t d;
    logic [5:0]     opcode;
    logic [5:0]     funct;
    opcode = instr[31:26];
    funct  = instr[5:0];
    d          = '0;
    d.op       = OP_RESERVED;
    d.rs       = instr[25:21];
    d.rt       = instr[20:16];
    d.rd       = instr[15:11];
    d.shamt    = instr[10:6];
    if (opcode == 6'h03)      d.writereg = 5'd31;
    else if (opcode == 6'h00) d.writereg = instr[15:11];
    else                      d.writereg = instr[20:16];
    if (opcode == 6'h0C || opcode == 6'h0D)
      d.extended_imm = {16'h0000, instr[15:0]};
    else
      d.extended_imm = {{16{instr[15]}}, instr[15:0]};
    case (opcode)
      6'h00: begin
        d.ctl.regwrite = 1'b1;
        case (funct)
          6'h21: d.op = OP_ADDU;
          6'h23: d.op = OP_SUBU;
          6'h2A: d.op = OP_SLT;
          6'h2B: d.op = OP_SLTU;
          6'h24: d.op = OP_AND;
          6'h27: d.op = OP_NOR;
          6'h25: d.op = OP_OR;
          6'h26: d.op = OP_XOR;
          6'h00: d.op = OP_SLL;
          6'h03: d.op = OP_SRA;
          6'h02: d.op = OP_SRL;
          6'h08: begin
            d.op           = OP_JR;
            d.ctl.regwrite = 1'b0;
            d.ctl.jump     = 1'b1;
            d.ctl.jump_reg = 1'b1;
          end
          default: d.ctl = '0;
        endcase
      end
      6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F: begin
        d.ctl.regwrite = 1'b1;
        d.ctl.alusrcb  = ALUSRC_IMM;
        case (opcode)
          6'h09:   d.op = OP_ADDU;
          6'h0A:   d.op = OP_SLT;
          6'h0B:   d.op = OP_SLTU;
          6'h0C:   begin d.op = OP_AND; d.ctl.zeroext = 1'b1; end
          6'h0D:   begin d.op = OP_OR;  d.ctl.zeroext = 1'b1; end
          default: d.op = OP_LUI;
        endcase
      end
      6'h04: begin d.op = OP_BEQ; d.ctl.branch = 1'b1; end
      6'h05: begin d.op = OP_BNE; d.ctl.branch = 1'b1; end
      6'h02: begin d.op = OP_J;   d.ctl.jump   = 1'b1; end
      6'h03: begin
        d.op           = OP_JAL;
        d.ctl.jump     = 1'b1;
        d.ctl.is_link  = 1'b1;
        d.ctl.regwrite = 1'b1;
      end
      6'h23: begin
        d.op           = OP_LW;
        d.ctl.regwrite = 1'b1;
        d.ctl.alusrcb  = ALUSRC_IMM;
        d.ctl.memread  = 1'b1;
      end
      6'h2B: begin
        d.op           = OP_SW;
        d.ctl.alusrcb  = ALUSRC_IMM;
        d.ctl.memwrite = 1'b1;
      end
      default: begin
        d.op  = OP_RESERVED;
        d.ctl = '0;
      end
    endcase
    return d;
  endfunction

  // Ready looks only at registered occupancy, so a full queue never takes
  // a word in the same cycle that issue frees space.
  assign w_in_ready   = (r_count != OCC_W'(DEPTH));
  assign w_enq        = bus.in_valid && w_in_ready && !bus.flush;
  assign bus.in_ready = w_in_ready;
  assign bus.count    = r_count;

  // Clamp the accept count to what is actually held (empty queue ignores it).
  always_comb begin
    w_accept_ext = SUM_W'(bus.out_accept);
    w_count_ext  = SUM_W'(r_count);
    w_k          = (w_accept_ext < w_count_ext) ? OCC_W'(w_accept_ext) : r_count;
    w_count_next = r_count + OCC_W'(w_enq) - w_k;
  end

  // Pointer and occupancy registers; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + PTR_W'(1);
      r_head  <= r_head + PTR_W'(w_k);
      r_count <= w_count_next;
    end
  end

  // Entry storage, written at the tail; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (w_enq && !reset) begin
      r_instr_mem[r_tail] <= bus.in_instr;
      r_pc_mem[r_tail]    <= bus.in_pc;
    end
  end

  // Issue window: slot gi reads entry (head + gi), wrapping with the pointer width.
  for (genvar gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_slot
    logic [PTR_W-1:0] w_idx;
    decoded_instr_t   w_dec;
    logic             w_valid;
    assign w_idx                = r_head + PTR_W'(gi);
    assign w_dec                = decode_instr(r_instr_mem[w_idx]);
    assign w_valid              = (r_count > OCC_W'(gi));
    assign bus.out_valid[gi]    = w_valid;
    assign bus.out_decoded[gi]  = w_dec;
    assign bus.out_pc[gi]       = r_pc_mem[w_idx];
    assign bus.out_reserved[gi] = w_valid && (w_dec.op == OP_RESERVED);
  end

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: a queue scoreboard tracks what should sit
// in the FIFO; each cycle the window, occupancy and ready are compared.
module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int IW    = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  decode_queue_if #(.DEPTH(DEPTH), .ISSUE_WIDTH(IW)) bus ();

  decode_queue #(.DEPTH(DEPTH), .ISSUE_WIDTH(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        rsvd;
  } entry_t;

  entry_t sb[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  int     n_cyc   = 0;
  decoded_instr_t d0;
  decoded_instr_t d1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // addiu $i,$0,i -- rt field doubles as an entry tag
  function automatic logic [31:0] mk(input int i);
    logic [31:0] w;
    w = 32'h24000000 | (32'(i & 31) << 16) | 32'(i & 16'hFFFF);
    return w;
  endfunction

  // One clock of stimulus; model update, then post-edge window check.
  task automatic cycle(input logic push, input logic [31:0] instr, input logic [31:0] pc,
                       input logic rsvd, input int accept, input logic fl, input logic rst);
    int     k;
    logic   do_enq;
    entry_t e;
    bus.in_valid   = push;
    bus.in_instr   = instr;
    bus.in_pc      = pc;
    bus.out_accept = 2'(accept);
    bus.flush      = fl;
    reset          = rst;
    #1;
    if (!rst) chk("in_ready", 64'(bus.in_ready), 64'(sb.size() != DEPTH));
    if (rst || fl) begin
      sb.delete();
    end else begin
      do_enq = push && (sb.size() != DEPTH);
      k = (accept < sb.size()) ? accept : sb.size();
      repeat (k) void'(sb.pop_front());
      if (do_enq) begin
        e.instr = instr;
        e.pc    = pc;
        e.rsvd  = rsvd;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid   = 1'b0;
    bus.out_accept = '0;
    bus.flush      = 1'b0;
    reset          = 1'b0;
    n_cyc++;
    $display("[TB] cyc %0d push=%0b pc=%h acc=%0d flush=%0b rst=%0b -> count=%0d valid=%b",
             n_cyc, push, pc, accept, fl, rst, bus.count, bus.out_valid);
    chk("count", 64'(bus.count), 64'(sb.size()));
    for (int i = 0; i < IW; i++) begin
      chk($sformatf("valid%0d", i), 64'(bus.out_valid[i]), 64'(sb.size() > i));
      if (sb.size() > i) begin
        chk($sformatf("pc%0d", i), 64'(bus.out_pc[i]), 64'(sb[i].pc));
        chk($sformatf("rt%0d", i), 64'(bus.out_decoded[i].rt), 64'(sb[i].instr[20:16]));
        chk($sformatf("rsvd%0d", i), 64'(bus.out_reserved[i]), 64'(sb[i].rsvd));
      end else begin
        chk($sformatf("rsvd_inv%0d", i), 64'(bus.out_reserved[i]), 64'd0);
      end
    end
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_instr   = '0;
    bus.in_pc      = '0;
    bus.flush      = 1'b0;
    bus.out_accept = '0;

    // Reset
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 0, 1'b0, 1'b1);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // addiu $1,$0,5
    cycle(1'b1, 32'h24010005, 32'h00400000, 1'b0, 0, 1'b0, 1'b0);
    d0 = bus.out_decoded[0];
    chk("addiu_op", 64'(d0.op), 64'(OP_ADDU));
    chk("addiu_writereg", 64'(d0.writereg), 64'd1);
    chk("addiu_imm", 64'(d0.extended_imm), 64'h00000005);
    chk("addiu_alusrcb", 64'(d0.ctl.alusrcb), 64'(ALUSRC_IMM));
    chk("addiu_regwrite", 64'(d0.ctl.regwrite), 64'd1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1, 1'b0, 1'b0);

    // ori vs addiu immediate extension
    cycle(1'b1, 32'h3402FFFF, 32'h00400004, 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, 32'h2403FFFF, 32'h00400008, 1'b0, 0, 1'b0, 1'b0);
    d0 = bus.out_decoded[0];
    d1 = bus.out_decoded[1];
    chk("ori_imm", 64'(d0.extended_imm), 64'h0000FFFF);
    chk("ori_zeroext", 64'(d0.ctl.zeroext), 64'd1);
    chk("ori_op", 64'(d0.op), 64'(OP_OR));
    chk("addiu_sext_imm", 64'(d1.extended_imm), 64'hFFFFFFFF);
    chk("addiu_zeroext", 64'(d1.ctl.zeroext), 64'd0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 2, 1'b0, 1'b0);

    // jal and a reserved opcode
    cycle(1'b1, 32'h0C000010, 32'h0040000C, 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, 32'hFC000000, 32'h00400010, 1'b1, 0, 1'b0, 1'b0);
    d0 = bus.out_decoded[0];
    d1 = bus.out_decoded[1];
    chk("jal_op", 64'(d0.op), 64'(OP_JAL));
    chk("jal_writereg", 64'(d0.writereg), 64'd31);
    chk("jal_is_link", 64'(d0.ctl.is_link), 64'd1);
    chk("rsv_op", 64'(d1.op), 64'(OP_RESERVED));
    chk("rsv_ctl", 64'(d1.ctl), 64'd0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 2, 1'b0, 1'b0);

    // Fill to full, then accept 2 while pushing (push must be refused)
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, mk(i), 32'h1000 + 32'(4 * i), 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, mk(9), 32'h10F0, 1'b0, 2, 1'b0, 1'b0);
    // Refill across the wrap and drain in order
    cycle(1'b1, mk(5), 32'h1014, 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, mk(6), 32'h1018, 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, mk(7), 32'h101C, 1'b0, 2, 1'b0, 1'b0);
    cycle(1'b1, mk(8), 32'h1020, 1'b0, 1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 2, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 2, 1'b0, 1'b0);
    // Over-accept at count=1, then accept on empty
    cycle(1'b1, mk(10), 32'h2000, 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 2, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 2, 1'b0, 1'b0);

    // count=3 then push+accept1 keeps 3
    for (int i = 0; i < 3; i++)
      cycle(1'b1, mk(11 + i), 32'h3000 + 32'(4 * i), 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, mk(14), 32'h300C, 1'b0, 1, 1'b0, 1'b0);
    // Flush with a simultaneous push and accept
    cycle(1'b1, mk(15), 32'h3010, 1'b0, 1, 1'b1, 1'b0);

    // Same again with reset mid-stream
    for (int i = 0; i < 3; i++)
      cycle(1'b1, mk(16 + i), 32'h4000 + 32'(4 * i), 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, mk(19), 32'h400C, 1'b0, 1, 1'b0, 1'b1);
    // Queue restarts cleanly
    cycle(1'b1, mk(20), 32'h5000, 1'b0, 0, 1'b0, 1'b0);
    chk("after_rst_pc", 64'(bus.out_pc[0]), 64'h5000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
